ada_i2s_rx: RTL and testbench

I2S receive controller for the audio digital-microphone (ADA) path. It sits directly upstream of the I/O ring. It generates the bit clock and word select that the ring drives onto `pad_ada_sck` and `pad_ada_ws`, and the L/R-select level for `pad_ada_lrs`. It deserializes `ada_sd` coming back from the ring and buffers the captured samples of the selected channel in a small FIFO, which the peripheral bus side drains over a valid/ready interface.

---
 rtl/ada_i2s_rx.sv | 176 +++++++++++++++++
 tb/tb_ada_i2s_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ada_i2s_rx.sv
// ada_i2s_rx - I2S receive controller for the ADA digital-microphone path.
//
// Generates the I2S bit clock (ada_sck) and word select (ada_ws) for the
// I/O ring, drives the microphone L/R select (ada_lrs), deserializes ada_sd
// for the selected channel and queues complete samples in a small FIFO that
// is drained over a valid/ready interface.
//
// Ports:
//   clk, rstn          system clock (rising edge), async active-low reset
//   en                 capture enable; low = idle (clocks parked low)
//   lrs_sel            channel to capture (0 = left/WS low, 1 = right/WS high),
//                      latched only while idle
//   ada_sck, ada_ws    bit clock / word select to the I/O ring (registered)
//   ada_lrs            microphone L/R select to the I/O ring (registered)
//   ada_sd             serial data from the I/O ring
//   sample_data        FIFO head, MSB-first two's complement, raw
//   sample_valid       FIFO non-empty
//   sample_ready       consumer pop (pop = valid && ready)
//   fifo_level         FIFO occupancy
//   overflow, ovf_clr  sticky dropped-sample flag and its clear
module ada_i2s_rx #(
  parameter int CLK_DIV    = 8,
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic                          lrs_sel,
  output logic                          ada_sck,
  output logic                          ada_ws,
  output logic                          ada_lrs,
  input  logic                          ada_sd,
  output logic [SAMPLE_W-1:0]           sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [DW-1:0] D_RISE    = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] D_FALL    = DW'(CLK_DIV - 1);
  localparam logic [4:0]    LAST_SLOT = 5'(SAMPLE_W);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] ONE_LVL   = LW'(1);

  // Serial front end
  logic [DW-1:0]       d_q, d_d;
  logic [5:0]          b_q, b_d;
  logic                sck_q, sck_d;
  logic                ws_q, ws_d;
  logic                lrs_q, lrs_d;
  logic                sd_q, sd_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] shifted;
  logic                push_q, push_d;

  // FIFO
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [SAMPLE_W-1:0] head_q, head_d;
  logic                ovf_q, ovf_d;

  logic rise, fall, capture;
  logic pop, full, wr, ovf_set;

  assign rise    = en && (d_q == D_RISE);
  assign fall    = en && (d_q == D_FALL);
  // Slot 0 of each half-frame is the I2S one-bit delay, so data lives in
  // slots 1..SAMPLE_W of the half-frame whose WS level matches lrs_q.
  assign capture = rise && (b_q[5] == lrs_q) && (b_q[4:0] != 5'd0) &&
                   (b_q[4:0] <= LAST_SLOT);

  if (SAMPLE_W == 1) begin : g_sw1
    assign shifted = sd_q;
  end else begin : g_swn
    assign shifted = {shift_q[SAMPLE_W-2:0], sd_q};
  end

  always_comb begin
    d_d     = '0;
    b_d     = '0;
    sck_d   = 1'b0;
    ws_d    = 1'b0;
    lrs_d   = lrs_q;
    sd_d    = ada_sd;
    shift_d = '0;
    push_d  = 1'b0;
    if (!en) begin
      lrs_d = lrs_sel;
    end else begin
      d_d     = (d_q == D_FALL) ? '0 : d_q + 1'b1;
      b_d     = fall ? b_q + 6'd1 : b_q;
      sck_d   = rise ? 1'b1 : (fall ? 1'b0 : sck_q);
      // WS follows the new bit count so it changes together with SCK falling.
      ws_d    = b_d[5];
      shift_d = capture ? shifted : shift_q;
      push_d  = capture && (b_q[4:0] == LAST_SLOT);
    end
  end

  // push_q is independent of en, so a sample completed just before en
  // drops still lands; shift_q holds it during the push cycle.
  always_comb begin
    pop      = sample_ready && (level_q != '0);
    full     = (level_q == FULL_LVL);
    wr       = push_q && (!full || pop);
    ovf_set  = push_q && full && !pop;
    wr_ptr_d = wr_ptr_q + AW'(wr);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(wr) - LW'(pop);
    ovf_d    = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    // Head register: the incoming sample becomes head when the FIFO is (or
    // is about to become) empty; otherwise a pop loads the next entry.
    head_d   = head_q;
    if (wr && ((level_q == '0) || (pop && (level_q == ONE_LVL)))) begin
      head_d = shift_q;
    end else if (pop && (level_q > ONE_LVL)) begin
      head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_q      <= '0;
      b_q      <= '0;
      sck_q    <= 1'b0;
      ws_q     <= 1'b0;
      lrs_q    <= 1'b0;
      sd_q     <= 1'b0;
      shift_q  <= '0;
      push_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      d_q      <= d_d;
      b_q      <= b_d;
      sck_q    <= sck_d;
      ws_q     <= ws_d;
      lrs_q    <= lrs_d;
      sd_q     <= sd_d;
      shift_q  <= shift_d;
      push_q   <= push_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ada_sck      = sck_q;
  assign ada_ws       = ws_q;
  assign ada_lrs      = lrs_q;
  assign sample_data  = head_q;
  assign sample_valid = (level_q != '0);
  assign fifo_level   = level_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ada_i2s_rx.sv
// tb_ada_i2s_rx - directed bench for ada_i2s_rx (CLK_DIV=8, SAMPLE_W=24,
// FIFO_DEPTH=8) with a behavioural I2S microphone driving ada_sd.
module tb_ada_i2s_rx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        lrs_sel;
  logic        ada_sck;
  logic        ada_ws;
  logic        ada_lrs;
  logic        ada_sd = 1'b0;
  logic [23:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        ovf_clr;

  ada_i2s_rx #(
    .CLK_DIV   (8),
    .SAMPLE_W  (24),
    .FIFO_DEPTH(8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .lrs_sel     (lrs_sel),
    .ada_sck     (ada_sck),
    .ada_ws      (ada_ws),
    .ada_lrs     (ada_lrs),
    .ada_sd      (ada_sd),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  // Microphone model: a new bit slot starts at every SCK falling edge; a WS
  // change restarts the slot count at 0, and WS 1->0 starts a new frame.
  // Slots 1..24 carry the frame's word for that channel MSB-first.
  logic [23:0] left_tab [16];
  logic [23:0] right_tab [16];
  int          slot = 0;
  int          frame = 0;
  logic        prev_sck = 1'b0;
  logic        prev_ws = 1'b0;

  always @(negedge clk) begin
    logic [23:0] word;
    if (en !== 1'b1) begin
      slot    = 0;
      frame   = 0;
      prev_ws = 1'b0;
    end else if (prev_sck && !ada_sck) begin
      if (ada_ws != prev_ws) begin
        if (!ada_ws) frame = frame + 1;
        slot = 0;
      end else begin
        slot = slot + 1;
      end
      prev_ws = ada_ws;
    end
    prev_sck = ada_sck;
    word = prev_ws ? right_tab[frame % 16] : left_tab[frame % 16];
    if (slot >= 1 && slot <= 24) ada_sd = word[24 - slot];
    else                         ada_sd = 1'b0;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cur = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cur += n;
  endtask

  task automatic goto_cyc(input int c);
    step(c - cur);
  endtask

  // Cycle 0 is the period in which en is first presented as 1.
  task automatic start();
    @(posedge clk);
    #1;
    en  = 1'b1;
    cur = 0;
  endtask

  task automatic pop_one(input string tag, input logic [23:0] exp);
    check_eq({tag, "_valid"}, 32'(sample_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(sample_data), 32'(exp));
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
  endtask

  task automatic fill_tabs(input logic [23:0] lbase, input logic [23:0] lstep,
                           input logic [23:0] rval);
    for (int i = 0; i < 16; i++) begin
      left_tab[i]  = lbase + 24'(i) * lstep;
      right_tab[i] = rval;
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; lrs_sel = 1'b0; sample_ready = 1'b0; ovf_clr = 1'b0;
    fill_tabs(24'h0, 24'h0, 24'h0);

    // ---- reset values ----
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sck",   32'(ada_sck),      32'd0);
    check_eq("rst_ws",    32'(ada_ws),       32'd0);
    check_eq("rst_lrs",   32'(ada_lrs),      32'd0);
    check_eq("rst_valid", 32'(sample_valid), 32'd0);
    check_eq("rst_data",  32'(sample_data),  32'd0);
    check_eq("rst_level", 32'(fifo_level),   32'd0);
    check_eq("rst_ovf",   32'(overflow),     32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(2);

    // ---- left capture ----
    fill_tabs(24'hA5C3F1, 24'h0, 24'hFFFFFF);
    lrs_sel = 1'b0;
    step(2);
    start();
    goto_cyc(3);   check_eq("l_sck_c3", 32'(ada_sck), 32'd0);
    goto_cyc(4);   check_eq("l_sck_c4", 32'(ada_sck), 32'd1);
    goto_cyc(8);   check_eq("l_sck_c8", 32'(ada_sck), 32'd0);
    goto_cyc(196); check_eq("l_valid_c196", 32'(sample_valid), 32'd0);
    goto_cyc(197);
    check_eq("l_valid_c197", 32'(sample_valid), 32'd1);
    check_eq("l_data_c197",  32'(sample_data),  32'hA5C3F1);
    check_eq("l_level_c197", 32'(fifo_level),   32'd1);
    check_eq("l_lrs",        32'(ada_lrs),      32'd0);
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    check_eq("l_valid_after_pop", 32'(sample_valid), 32'd0);
    goto_cyc(255); check_eq("l_ws_c255", 32'(ada_ws), 32'd0);
    goto_cyc(256); check_eq("l_ws_c256", 32'(ada_ws), 32'd1);
    goto_cyc(511); check_eq("l_ws_c511", 32'(ada_ws), 32'd1);
    goto_cyc(512);
    check_eq("l_ws_c512",    32'(ada_ws),     32'd0);
    check_eq("l_level_c512", 32'(fifo_level), 32'd0);
    goto_cyc(709);
    check_eq("l_valid_c709", 32'(sample_valid), 32'd1);
    check_eq("l_data_c709",  32'(sample_data),  32'hA5C3F1);
    en = 1'b0;
    step(2);
    pop_one("l_drain", 24'hA5C3F1);

    // ---- right capture ----
    fill_tabs(24'h654321, 24'h0, 24'h123456);
    lrs_sel = 1'b1;
    step(2);
    check_eq("r_lrs", 32'(ada_lrs), 32'd1);
    start();
    goto_cyc(452); check_eq("r_valid_c452", 32'(sample_valid), 32'd0);
    goto_cyc(453);
    check_eq("r_valid_c453", 32'(sample_valid), 32'd1);
    check_eq("r_data_c453",  32'(sample_data),  32'h123456);
    goto_cyc(964); check_eq("r_level_c964", 32'(fifo_level), 32'd1);
    goto_cyc(965); check_eq("r_level_c965", 32'(fifo_level), 32'd2);
    en = 1'b0;
    lrs_sel = 1'b0;
    step(2);
    check_eq("r_lrs_back", 32'(ada_lrs), 32'd0);
    pop_one("r_pop0", 24'h123456);
    pop_one("r_pop1", 24'h123456);
    check_eq("r_empty", 32'(sample_valid), 32'd0);

    // ---- asynchronous reset mid-frame with 3 samples queued ----
    fill_tabs(24'h000100, 24'h1, 24'h0);
    start();
    goto_cyc(1300);
    check_eq("x_level_pre", 32'(fifo_level), 32'd3);
    check_eq("x_sck_pre",   32'(ada_sck),    32'd1);
    check_eq("x_ws_pre",    32'(ada_ws),     32'd1);
    @(negedge clk);
    rstn = 1'b0;
    en   = 1'b0;
    #1;
    check_eq("x_sck",   32'(ada_sck),      32'd0);
    check_eq("x_ws",    32'(ada_ws),       32'd0);
    check_eq("x_valid", 32'(sample_valid), 32'd0);
    check_eq("x_data",  32'(sample_data),  32'd0);
    check_eq("x_level", 32'(fifo_level),   32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(2);
    check_eq("x_level_post", 32'(fifo_level),   32'd0);
    check_eq("x_valid_post", 32'(sample_valid), 32'd0);

    // ---- overflow: 9 frames, no pops ----
    fill_tabs(24'h000001, 24'h1, 24'hFFFFFF);
    start();
    goto_cyc(3781); check_eq("o_level_full", 32'(fifo_level), 32'd8);
    goto_cyc(4292);
    check_eq("o_ovf_c4292",   32'(overflow),   32'd0);
    check_eq("o_level_c4292", 32'(fifo_level), 32'd8);
    goto_cyc(4293);
    check_eq("o_ovf_c4293",   32'(overflow),   32'd1);
    check_eq("o_level_c4293", 32'(fifo_level), 32'd8);
    en = 1'b0;
    step(1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check_eq("o_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) pop_one($sformatf("o_pop%0d", i), 24'(i + 1));
    check_eq("o_empty", 32'(sample_valid), 32'd0);

    // ---- full FIFO with push and pop in the same cycle ----
    fill_tabs(24'h000011, 24'h1, 24'hFFFFFF);
    start();
    goto_cyc(4292);
    check_eq("f_level_pre", 32'(fifo_level), 32'd8);
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    check_eq("f_level", 32'(fifo_level),  32'd8);
    check_eq("f_ovf",   32'(overflow),    32'd0);
    check_eq("f_head",  32'(sample_data), 32'h12);
    en = 1'b0;
    step(2);
    for (int i = 0; i < 8; i++) pop_one($sformatf("f_pop%0d", i), 24'(24'h12 + i));
    check_eq("f_empty", 32'(sample_valid), 32'd0);

    // ---- disable mid-sample, then re-enable ----
    fill_tabs(24'hA5C3F1, 24'h0, 24'hFFFFFF);
    start();
    goto_cyc(100);
    check_eq("d_sck_c100", 32'(ada_sck), 32'd1);
    en = 1'b0;
    step(1);
    check_eq("d_sck_off", 32'(ada_sck), 32'd0);
    check_eq("d_ws_off",  32'(ada_ws),  32'd0);
    goto_cyc(400);
    check_eq("d_no_push", 32'(fifo_level), 32'd0);
    fill_tabs(24'h5A0F3C, 24'h0, 24'hFFFFFF);
    start();
    goto_cyc(196); check_eq("d_valid_c196", 32'(sample_valid), 32'd0);
    goto_cyc(197);
    check_eq("d_valid_c197", 32'(sample_valid), 32'd1);
    check_eq("d_data_c197",  32'(sample_data),  32'h5A0F3C);
    en = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
